// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard event controller.
//   - prefix / modifier scan-code constants (Set 2)
//   - prefix FSM state type
//   - discard-code test and base (lowercase) scan-to-ASCII table
package ps2_pkg;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  // Keyboard status/response bytes that are never part of a key event.
  function automatic logic is_discard(input logic [7:0] code);
    return code inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  // Lowercase ASCII for a mapped make code; 8'h00 means "not mapped".
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
      8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
      8'h3E: a = "8";  8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      8'h76: a = 8'h1B;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: show-ahead FIFO of ASCII key codes.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data; dropped when full unless a pop happens too
//   rd_en      : pop the head; ignored when empty
//   rd_data    : head entry (8'h00 when empty)
//   full/empty : occupancy flags
module ps2_key_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot the same-cycle push needs, so a full FIFO still accepts.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 Set 2 scan-code stream to queued ASCII key events.
//   clk, rst_n  : clock, asynchronous active-low reset
//   byte_valid  : strobe, byte_in holds one received scan-code byte
//   byte_in     : raw scan-code byte
//   rd_en       : CPU pop of the FIFO head (ignored when key_valid=0)
//   clr_ovf     : clear the sticky overflow flag
//   key_valid   : FIFO non-empty
//   key_data    : ASCII at FIFO head, 8'h00 when empty
//   fifo_full   : FIFO holds DEPTH entries
//   overflow    : sticky, a translated key was dropped on a full FIFO
//   shift_on    : either Shift held
//   caps_on     : Caps Lock toggle state
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic       key_valid,
  output logic [7:0] key_data,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_on,
  output logic       caps_on
);

  prefix_state_t state;
  logic          lshift;
  logic          rshift;
  logic          pend_valid;
  logic [7:0]    pend_data;
  logic [7:0]    base_ascii;
  logic [7:0]    xlat;
  logic          fifo_empty;
  logic          ovf_set;

  assign shift_on = lshift | rshift;

  // Case uses the modifier state before the current edge.
  always_comb begin
    base_ascii = scan_to_ascii(byte_in);
    xlat       = base_ascii;
    if (base_ascii >= 8'h61 && base_ascii <= 8'h7A && (shift_on ^ caps_on))
      xlat = base_ascii - 8'h20;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_on    <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      pend_valid <= 1'b0;
      if (byte_valid) begin
        if (is_discard(byte_in)) begin
          state <= ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: begin
              if (byte_in == CODE_E0)      state <= ST_EXT;
              else if (byte_in == CODE_F0) state <= ST_BRK;
              else begin
                state <= ST_IDLE;
                if (byte_in == CODE_LSHIFT)      lshift  <= 1'b1;
                else if (byte_in == CODE_RSHIFT) rshift  <= 1'b1;
                else if (byte_in == CODE_CAPS)   caps_on <= ~caps_on;
                else if (base_ascii != 8'h00) begin
                  pend_valid <= 1'b1;
                  pend_data  <= xlat;
                end
              end
            end
            ST_EXT: begin
              if (byte_in == CODE_F0)      state <= ST_EXT_BRK;
              else if (byte_in == CODE_E0) state <= ST_EXT;
              else                         state <= ST_IDLE;
            end
            ST_BRK: begin
              state <= ST_IDLE;
              if (byte_in == CODE_LSHIFT)      lshift <= 1'b0;
              else if (byte_in == CODE_RSHIFT) rshift <= 1'b0;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign key_valid = !fifo_empty;
  assign ovf_set   = pend_valid && fifo_full && !(rd_en && key_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  ps2_key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pend_valid),
    .wr_data (pend_data),
    .rd_en   (rd_en),
    .rd_data (key_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed scenarios plus random byte streams against a
// queue-based reference model of the key controller.
module tb_ps2_key_ctrl;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       key_valid;
  logic [7:0] key_data;
  logic       fifo_full;
  logic       overflow;
  logic       shift_on;
  logic       caps_on;

  ps2_key_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .shift_on   (shift_on),
    .caps_on    (caps_on)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_ext, m_brk;
  bit         m_ls, m_rs, m_caps, m_ovf;
  bit         m_pend_v;
  logic [7:0] m_pend_d;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic model_reset();
    m_q.delete();
    m_ext = 0; m_brk = 0;
    m_ls = 0; m_rs = 0; m_caps = 0; m_ovf = 0;
    m_pend_v = 0; m_pend_d = '0;
  endtask

  task automatic model_make(input logic [7:0] b);
    bit upper;
    upper = (m_ls | m_rs) ^ m_caps;
    if (b == 8'h12) begin m_ls = 1; return; end
    if (b == 8'h59) begin m_rs = 1; return; end
    if (b == 8'h58) begin m_caps = !m_caps; return; end
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == b) begin
        m_pend_v = 1;
        m_pend_d = 8'(int'("a") + i - (upper ? 32 : 0));
        return;
      end
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == b) begin
        m_pend_v = 1;
        m_pend_d = 8'(int'("0") + i);
        return;
      end
    case (b)
      8'h29: begin m_pend_v = 1; m_pend_d = 8'h20; end
      8'h5A: begin m_pend_v = 1; m_pend_d = 8'h0D; end
      8'h66: begin m_pend_v = 1; m_pend_d = 8'h08; end
      8'h76: begin m_pend_v = 1; m_pend_d = 8'h1B; end
      default: ;
    endcase
  endtask

  // Model of one clock edge given the inputs present before it.
  task automatic model_edge(input bit bv, input logic [7:0] b, input bit rd, input bit clr);
    bit ovf_set;
    ovf_set = 0;
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend_v) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend_d);
      else ovf_set = 1;
    end
    if (ovf_set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_pend_v = 0;
    if (bv) begin
      if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
        m_ext = 0; m_brk = 0;
      end else if (!m_brk && b == 8'hE0) begin
        m_ext = 1;
      end else if (!m_brk && b == 8'hF0) begin
        m_brk = 1;
      end else begin
        if (!m_ext) begin
          if (!m_brk) model_make(b);
          else if (b == 8'h12) m_ls = 0;
          else if (b == 8'h59) m_rs = 0;
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("key_valid", 8'(key_valid), 8'(m_q.size() > 0));
    check("key_data",  key_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check("fifo_full", 8'(fifo_full), 8'(m_q.size() == DEPTH));
    check("overflow",  8'(overflow), 8'(m_ovf));
    check("shift_on",  8'(shift_on), 8'(m_ls | m_rs));
    check("caps_on",   8'(caps_on), 8'(m_caps));
  endtask

  task automatic cycle(input bit bv, input logic [7:0] b, input bit rd, input bit clr);
    @(negedge clk);
    byte_valid = bv; byte_in = b; rd_en = rd; clr_ovf = clr;
    @(posedge clk);
    model_edge(bv, b, rd, clr);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1, b, 0, 0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, 8'h00, 0, 0);
  endtask

  task automatic pop();
    cycle(0, 8'h00, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; byte_valid = 0; byte_in = '0; rd_en = 0; clr_ovf = 0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] pool [16];
    int unsigned k;
    pool = '{8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'h29, 8'h5A, 8'h66,
             8'h76, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h05, 8'hF0, 8'hE0};
    k = $urandom_range(0, 9);
    if (k < 4) return LETTERS[$urandom_range(0, 25)];
    if (k < 5) return DIGITS[$urandom_range(0, 9)];
    if (k < 9) return pool[$urandom_range(0, 15)];
    return 8'($urandom);
  endfunction

  initial begin
    model_reset();
    do_reset();

    // 1: make/break of 'a', then pop
    send(8'h1C); send(8'hF0); send(8'h1C);
    idle(2); pop(); idle(1);

    // 2: shift and caps lock
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    send(8'h58); send(8'h1C); idle(2);
    pop(); pop(); pop(); idle(1);

    // 3: extended events ignored
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    send(8'h16); idle(2); pop();

    // 4: fill, overflow, clear, push+pop at full
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'h29);
    idle(2);
    send(8'h29); idle(2);
    cycle(0, 8'h00, 0, 1);
    send(8'h29);
    pop();
    idle(2);
    for (int i = 0; i < DEPTH; i++) pop();

    // 5: reset mid-prefix
    send(8'hF0);
    do_reset();
    send(8'h1C); idle(2); pop();

    // 6: unmapped and discarded codes
    send(8'h05); send(8'hE0); send(8'hAA); send(8'h5A); idle(2); pop(); idle(1);

    // Random streams
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 6, rand_byte(),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end
    idle(2);
    for (int i = 0; i < DEPTH + 1; i++) pop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
